truth_table_sequencer: RTL and testbench
========================================

// Module: truth_table_sequencer
// PURPOSE
//  Upstream stimulus/downstream capture stage for the 2-input gate exercises.
//  On start: drives every input combination (000..0 to 11..1) into the gate, waits a settle time,
//   samples the gate output, and builds the observed truth table.
//  Compares the table against an expected table and reports pass/fail and the mismatch count.
//  Replaces hand-written #1 stimulus lists with a clocked, self-checking sequencer.
// PARAMETERS
//  N_IN      2        number of gate inputs; in_vec width; table has 2**N_IN rows
//  EXPECTED  4'b0010  expected table; bit k = expected s for in_vec==k (default: ~a & b)
//  SETTLE    1        cycles waited in WAIT before sampling (0 = skip WAIT)
// PORTS
//  clk        in   1          single clock, rising edge
//  reset      in   1          synchronous, active-high
//  start      in   1          begin a sweep; honoured only in IDLE
//  s_in       in   1          gate output under test
//  in_vec     out  N_IN       gate inputs; MSB = a, LSB = b for N_IN=2
//  busy       out  1          high in every state except IDLE
//  done       out  1          one-cycle pulse in FINISH
//  table_out  out  2**N_IN    captured truth table, bit k = s_in sampled for in_vec==k
//  pass       out  1          table_out==EXPECTED; valid from done, held until next start
//  err_count  out  N_IN+1     number of mismatching rows (0..2**N_IN)
// BEHAVIOUR
//  Reset: state=IDLE; in_vec, table_out, err_count, pass, done, busy and idx all 0.
//   Applies on any cycle, including mid-sweep; the sweep is aborted and no done is pulsed.
//  FSM (all outputs registered):
//   IDLE:   start=1 -> APPLY; idx<=0, in_vec<=0, table_out<=0, err_count<=0, pass<=0.
//   APPLY:  1 cycle, in_vec stable = idx; -> WAIT (load cnt=SETTLE-1) or SAMPLE if SETTLE==0.
//   WAIT:   cnt==0 -> SAMPLE else cnt--.
//   SAMPLE: table_out[idx]<=s_in; if s_in!=EXPECTED[idx], err_count++.
//           idx==2**N_IN-1 -> FINISH; else idx++, in_vec<=idx+1, -> APPLY.
//   FINISH: done=1 for this cycle only; pass=(table_out==EXPECTED) using the final row; -> IDLE.
//  Timing:
//   Each row takes SETTLE+2 cycles.
//   done is high in the cycle that starts (2**N_IN)*(SETTLE+2) edges after the edge that accepted start.
//   Defaults: 12 edges.
//  in_vec changes only on the SAMPLE->APPLY transition and on start acceptance.
//   It holds its last value (all ones) after the sweep until the next start.
//  start while busy, including during FINISH, is ignored and not queued.
//  idx wraps never: the sweep terminates at the last row. err_count cannot overflow (N_IN+1 bits).
//  s_in is sampled only in SAMPLE; glitches in other states have no effect.
//  Coverage: 2**N_IN <= 32 required (N_IN <= 5).
// STRUCTURE
//  Shared include truth_table_defs.vh: state encodings IDLE=0, APPLY=1, WAIT=2, SAMPLE=3, FINISH=4;
//   3-bit state width.
//  One sub-module: settle_timer (load value, enable, zero flag), width $clog2(SETTLE+1), min 1.
//  The gate under test is instantiated only in the bench, never inside this block.
// TESTING
//  1 reset=1 for 2 cycles -> all outputs 0, busy=0.
//  2 s_in = ~a & b gate, pulse start -> done after 12 edges, table_out=4'b0010, err_count=0, pass=1.
//  3 s_in tied 1 -> table_out=4'b1111, err_count=3, pass=0.
//  4 start held high for whole sweep plus pulse start mid-sweep -> exactly one sweep, single done pulse.
//  5 reset asserted at edge 5 of a sweep -> next cycle IDLE, in_vec=0, no done.
//    A following start gives a clean sweep with pass=1.
//  6 SETTLE=0, N_IN=3, EXPECTED=8'h80 with 3-input AND -> done after 16 edges, pass=1.

Source files
------------

// File: rtl/truth_table_sequencer_pkg.sv
// Shared definitions for the truth-table sequencer.
//   state_t      : FSM state encoding (IDLE=0, APPLY=1, WAIT=2, SAMPLE=3, FINISH=4), 3 bits wide
//   settle_width : width of the settle counter for a given SETTLE value, never below 1
package truth_table_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_APPLY  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    function automatic int settle_width(input int settle);
        int w;
        w = $clog2(settle + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/truth_table_sequencer_if.sv
// Signal bundle between the sequencer and the gate under test / the observer.
//   start      : request a sweep (to sequencer)
//   s_in       : gate output under test (to sequencer)
//   in_vec     : gate inputs driven by the sequencer
//   busy, done : sweep in progress / one-cycle completion pulse
//   table_out  : captured truth table, bit k = s_in observed for in_vec==k
//   pass       : captured table equals the expected table
//   err_count  : number of rows that differ from the expected table
//
// Handshake: start is a level request with no ready; it is taken only on a
// clock edge where busy is low, and any start seen while busy is dropped, not
// queued. done is a single-cycle pulse; table_out, pass and err_count are
// valid from done and held until the next accepted start.
interface truth_table_sequencer_if #(
    parameter int N_IN = 2
);
    logic                   start;
    logic                   s_in;
    logic [N_IN-1:0]        in_vec;
    logic                   busy;
    logic                   done;
    logic [(1<<N_IN)-1:0]   table_out;
    logic                   pass;
    logic [N_IN:0]          err_count;

    modport master (
        input  start, s_in,
        output in_vec, busy, done, table_out, pass, err_count
    );

    modport slave (
        output start, s_in,
        input  in_vec, busy, done, table_out, pass, err_count
    );
endinterface

// File: rtl/truth_table_sequencer_settle_timer.sv
// Down-counter that times the settle interval between driving a row and
// sampling the gate output.
//   clk, reset : clock, synchronous active-high reset
//   load       : load load_val (wins over en)
//   en         : decrement while non-zero
//   load_val   : value loaded on load
//   zero       : counter currently reads zero
module truth_table_sequencer_settle_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         zero
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);
endmodule

// File: rtl/truth_table_sequencer.sv
// Clocked stimulus/capture sequencer for small combinational gates. On start
// it drives every input combination 0..2**N_IN-1, waits SETTLE cycles per row,
// samples the gate output, builds the observed truth table and compares it
// with EXPECTED.
//   clk, reset : clock, synchronous active-high reset (aborts a sweep, no done)
//   bus        : master side of truth_table_sequencer_if (start/s_in in,
//                in_vec/busy/done/table_out/pass/err_count out, all registered)
//   dbg_state  : current FSM state
module truth_table_sequencer
    import truth_table_sequencer_pkg::*;
#(
    parameter int                   N_IN     = 2,
    parameter logic [(1<<N_IN)-1:0] EXPECTED = 4'b0010,
    parameter int                   SETTLE   = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    truth_table_sequencer_if.master bus,
    output state_t                  dbg_state
);
    localparam int                ROWS     = 1 << N_IN;
    localparam int                TW       = settle_width(SETTLE);
    localparam logic [TW-1:0]     LOAD_VAL = TW'((SETTLE > 0) ? SETTLE - 1 : 0);
    localparam logic [N_IN-1:0]   LAST_IDX = N_IN'(ROWS - 1);

    state_t            state_q, state_d;
    logic [N_IN-1:0]   idx_q, idx_d;
    logic [N_IN-1:0]   in_vec_q, in_vec_d;
    logic [ROWS-1:0]   table_q, table_d;
    logic [N_IN:0]     err_q, err_d;
    logic              pass_q, pass_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              timer_load, timer_en, timer_zero;

    truth_table_sequencer_settle_timer #(.W(TW)) u_settle_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .en       (timer_en),
        .load_val (LOAD_VAL),
        .zero     (timer_zero)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        in_vec_d   = in_vec_q;
        table_d    = table_q;
        err_d      = err_q;
        pass_d     = pass_q;
        timer_load = 1'b0;
        timer_en   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d  = ST_APPLY;
                    idx_d    = '0;
                    in_vec_d = '0;
                    table_d  = '0;
                    err_d    = '0;
                    pass_d   = 1'b0;
                end
            end
            ST_APPLY: begin
                timer_load = 1'b1;
                state_d    = (SETTLE == 0) ? ST_SAMPLE : ST_WAIT;
            end
            ST_WAIT: begin
                timer_en = 1'b1;
                if (timer_zero) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                table_d[idx_q] = bus.s_in;
                if (bus.s_in != EXPECTED[idx_q]) begin
                    err_d = err_q + (N_IN + 1)'(1);
                end
                if (idx_q == LAST_IDX) begin
                    state_d = ST_FINISH;
                    // Compare the table including the row captured right now,
                    // so pass is already valid in the cycle done is high.
                    pass_d  = (table_d == EXPECTED);
                end else begin
                    idx_d    = idx_q + N_IN'(1);
                    in_vec_d = idx_q + N_IN'(1);
                    state_d  = ST_APPLY;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // busy/done are registered copies of the next-state decode so they line
    // up exactly with the state register.
    always_comb begin
        done_d = (state_d == ST_FINISH);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            in_vec_q <= '0;
            table_q  <= '0;
            err_q    <= '0;
            pass_q   <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            in_vec_q <= in_vec_d;
            table_q  <= table_d;
            err_q    <= err_d;
            pass_q   <= pass_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.in_vec    = in_vec_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.table_out = table_q;
    assign bus.pass      = pass_q;
    assign bus.err_count = err_q;
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_truth_table_sequencer.sv
// Bench for truth_table_sequencer: a default instance (N_IN=2, SETTLE=1,
// EXPECTED=4'b0010) and a 3-input instance (SETTLE=0, EXPECTED=8'h80).
// A timing model predicts every output from the number of edges since the
// accepted start; a compare process checks both instances every cycle.
module tb_truth_table_sequencer;
    import truth_table_sequencer_pkg::*;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic [2:0] in_vec;
        logic [7:0] tbl;
        logic [3:0] err;
        logic       pass;
    } exp_t;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    truth_table_sequencer_if #(.N_IN(2)) if0 ();
    truth_table_sequencer_if #(.N_IN(3)) if1 ();
    state_t dbg0, dbg1;

    logic [3:0] gate0;
    logic [7:0] gate1;
    logic [1:0] noise;
    int         n_checks;
    int         n_errors;
    bit         chk_en;

    truth_table_sequencer u0 (
        .clk       (clk),
        .reset     (rst),
        .bus       (if0),
        .dbg_state (dbg0)
    );

    truth_table_sequencer #(.N_IN(3), .EXPECTED(8'h80), .SETTLE(0)) u1 (
        .clk       (clk),
        .reset     (rst),
        .bus       (if1),
        .dbg_state (dbg1)
    );

    // ---------------- reference model ----------------
    function automatic int per_of(input int i);
        return (i == 0) ? 3 : 2;          // SETTLE + 2 cycles per row
    endfunction
    function automatic int rows_of(input int i);
        return (i == 0) ? 4 : 8;
    endfunction
    function automatic int tsw(input int i);
        return rows_of(i) * per_of(i);    // edges from accepted start to done
    endfunction
    function automatic logic [7:0] exp_tbl(input int i);
        return (i == 0) ? 8'h02 : 8'h80;
    endfunction

    // Outputs expected j edges after the accepted start with gate table g.
    function automatic exp_t model(input int i, input bit active, input int j, input logic [7:0] g);
        exp_t       e;
        int         nrow;
        logic [7:0] ex;
        e  = '0;
        ex = exp_tbl(i);
        if (!active) return e;
        nrow = j / per_of(i);
        if (nrow > rows_of(i)) nrow = rows_of(i);
        e.busy   = (j <= tsw(i));
        e.done   = (j == tsw(i));
        e.in_vec = 3'((nrow >= rows_of(i)) ? rows_of(i) - 1 : nrow);
        for (int k = 0; k < nrow; k++) begin
            e.tbl[k] = g[k];
            if (g[k] != ex[k]) e.err = e.err + 4'd1;
        end
        e.pass = (j >= tsw(i)) && (e.err == 4'd0);
        return e;
    endfunction

    function automatic bit in_sample(input int i, input bit active, input int j);
        return active && (j < tsw(i)) && ((j % per_of(i)) == per_of(i) - 1);
    endfunction

    bit         m_active [2];
    int         m_j      [2];
    logic [7:0] m_gate   [2];
    logic [1:0] start_v;
    logic [7:0] gate_v   [2];

    assign start_v   = {if1.start, if0.start};
    assign gate_v[0] = {4'h0, gate0};
    assign gate_v[1] = gate1;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_active[i] <= 1'b0;
                m_j[i]      <= 0;
            end else if ((!m_active[i] || m_j[i] > tsw(i)) && start_v[i]) begin
                m_active[i] <= 1'b1;
                m_j[i]      <= 0;
                m_gate[i]   <= gate_v[i];
            end else if (m_active[i] && m_j[i] <= tsw(i)) begin
                m_j[i] <= m_j[i] + 1;
            end
        end
    end

    // Gates under test; noise toggles s_in in every cycle except the sampling one.
    assign if0.s_in = gate0[if0.in_vec] ^ (noise[0] & ~in_sample(0, m_active[0], m_j[0]));
    assign if1.s_in = gate1[if1.in_vec] ^ (noise[1] & ~in_sample(1, m_active[1], m_j[1]));

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                e = model(0, m_active[0], m_j[0], m_gate[0]);
                chk("busy0",   32'(if0.busy),      32'(e.busy));
                chk("done0",   32'(if0.done),      32'(e.done));
                chk("in_vec0", 32'(if0.in_vec),    32'(e.in_vec));
                chk("table0",  32'(if0.table_out), 32'(e.tbl));
                chk("err0",    32'(if0.err_count), 32'(e.err));
                chk("pass0",   32'(if0.pass),      32'(e.pass));
                e = model(1, m_active[1], m_j[1], m_gate[1]);
                chk("busy1",   32'(if1.busy),      32'(e.busy));
                chk("done1",   32'(if1.done),      32'(e.done));
                chk("in_vec1", 32'(if1.in_vec),    32'(e.in_vec));
                chk("table1",  32'(if1.table_out), 32'(e.tbl));
                chk("err1",    32'(if1.err_count), 32'(e.err));
                chk("pass1",   32'(if1.pass),      32'(e.pass));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_start(input int which);
        @(negedge clk);
        for (int n = 0; n < 100 && ((which == 0) ? if0.busy : if1.busy); n++) @(negedge clk);
        if (which == 0) if0.start = 1'b1;
        else            if1.start = 1'b1;
        @(posedge clk);
        #1;
        if0.start = 1'b0;
        if1.start = 1'b0;
    endtask

    task automatic wait_done(input int which, output int edges);
        bit seen;
        seen  = 1'b0;
        edges = 0;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(posedge clk);
            #1;
            edges++;
            seen = (which == 0) ? if0.done : if1.done;
        end
        chk("done_seen", 32'(seen), 32'd1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int edges;
        int dones;
        n_checks  = 0;
        n_errors  = 0;
        chk_en    = 1'b0;
        rst       = 1'b1;
        if0.start = 1'b0;
        if1.start = 1'b0;
        gate0     = 4'h0;
        gate1     = 8'h00;
        noise     = 2'b00;

        // 1: reset for two cycles
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        chk("rst_busy0",  32'(if0.busy),      32'd0);
        chk("rst_done0",  32'(if0.done),      32'd0);
        chk("rst_in_vec0",32'(if0.in_vec),    32'd0);
        chk("rst_table0", 32'(if0.table_out), 32'd0);
        chk("rst_err0",   32'(if0.err_count), 32'd0);
        chk("rst_pass0",  32'(if0.pass),      32'd0);
        chk("rst_state0", 32'(dbg0),          32'(ST_IDLE));
        chk("rst_state1", 32'(dbg1),          32'(ST_IDLE));
        chk("rst_busy1",  32'(if1.busy),      32'd0);
        @(negedge clk);
        rst = 1'b0;

        // 2: ~a & b gate
        gate0 = 4'b0010;
        pulse_start(0);
        wait_done(0, edges);
        chk("andn_edges", 32'(edges),         32'd12);
        chk("andn_table", 32'(if0.table_out), 32'h2);
        chk("andn_err",   32'(if0.err_count), 32'd0);
        chk("andn_pass",  32'(if0.pass),      32'd1);

        // 3: s_in tied high
        gate0 = 4'hF;
        pulse_start(0);
        wait_done(0, edges);
        chk("one_edges", 32'(edges),         32'd12);
        chk("one_table", 32'(if0.table_out), 32'hF);
        chk("one_err",   32'(if0.err_count), 32'd3);
        chk("one_pass",  32'(if0.pass),      32'd0);

        // 4a: start held high through the sweep
        gate0 = 4'b0010;
        @(negedge clk);
        for (int n = 0; n < 100 && if0.busy; n++) @(negedge clk);
        if0.start = 1'b1;
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (if0.done) begin
                dones++;
                if0.start = 1'b0;
            end
        end
        if0.start = 1'b0;
        chk("held_start_dones", 32'(dones), 32'd1);

        // 4b: extra start mid-sweep and during FINISH
        pulse_start(0);
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (if0.done) dones++;
            if0.start = (c == 4) || if0.done;
        end
        if0.start = 1'b0;
        chk("extra_start_dones", 32'(dones), 32'd1);

        // 5: reset at edge 5 of a sweep
        pulse_start(0);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("abort_busy",   32'(if0.busy),      32'd0);
        chk("abort_in_vec", 32'(if0.in_vec),    32'd0);
        chk("abort_done",   32'(if0.done),      32'd0);
        chk("abort_table",  32'(if0.table_out), 32'd0);
        chk("abort_state",  32'(dbg0),          32'(ST_IDLE));
        dones = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (if0.done) dones++;
        end
        chk("abort_no_done", 32'(dones), 32'd0);
        pulse_start(0);
        wait_done(0, edges);
        chk("after_abort_edges", 32'(edges),         32'd12);
        chk("after_abort_pass",  32'(if0.pass),      32'd1);
        chk("after_abort_table", 32'(if0.table_out), 32'h2);

        // 6: 3-input AND, SETTLE=0
        gate1 = 8'h80;
        pulse_start(1);
        wait_done(1, edges);
        chk("and3_edges", 32'(edges),         32'd16);
        chk("and3_pass",  32'(if1.pass),      32'd1);
        chk("and3_table", 32'(if1.table_out), 32'h80);
        chk("and3_err",   32'(if1.err_count), 32'd0);

        // random: gates, glitches on s_in, stray starts, occasional reset
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk);
            noise = 2'($urandom_range(0, 3));
            rst   = ($urandom_range(0, 199) == 0);
            if ((!m_active[0] || m_j[0] > tsw(0)) && $urandom_range(0, 3) == 0)
                gate0 = ($urandom_range(0, 1) == 0) ? 4'b0010 : 4'($urandom_range(0, 15));
            if ((!m_active[1] || m_j[1] > tsw(1)) && $urandom_range(0, 3) == 0)
                gate1 = ($urandom_range(0, 1) == 0) ? 8'h80 : 8'($urandom_range(0, 255));
            if0.start = ($urandom_range(0, 7) == 0);
            if1.start = ($urandom_range(0, 7) == 0);
        end
        @(negedge clk);
        rst       = 1'b0;
        noise     = 2'b00;
        if0.start = 1'b0;
        if1.start = 1'b0;
        repeat (30) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
